sigdiv_iter: RTL and testbench
==============================

SIGDIV_ITER -- requirements
Module: sigdiv_iter

Interface
REQ-001 Parameter: P, cvw_t (no default; supplied by the core configuration); P.NF is the fraction width, so significands are P.NF+1 bits.
REQ-002 Port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port Start, input, 1, request to begin a divide; sampled only while Ready=1.
REQ-005 Port Flush, input, 1, abort any operation; overrides Start.
REQ-006 Port Xm, input, P.NF+1, dividend significand (normalized, MSB=1); captured on the accepting edge.
REQ-007 Port Ym, input, P.NF+1, divisor significand (normalized, MSB=1); captured on the accepting edge.
REQ-008 Port Ready, output, 1, high only in IDLE.
REQ-009 Port Busy, output, 1, high only in BUSY.
REQ-010 Port Done, output, 1, one-cycle result-valid pulse.
REQ-011 Port Qm, output, P.NF+3, quotient: 1 integer bit and P.NF+2 fraction bits.
REQ-012 Port Sticky, output, 1, final remainder nonzero.
REQ-013 Port DivErr, output, 1, divisor not normalized (Ym MSB=0).

Function
REQ-014 States SHALL be IDLE, BUSY and DONE; Ready=(IDLE), Busy=(BUSY), Done=(DONE).
REQ-015 IDLE with Start=1 and Flush=0: capture operands; remainder R<=Xm (P.NF+2 bits); quotient register Q<=0; counter<=0; go to BUSY.
REQ-016 Each BUSY edge SHALL do one restoring radix-2 step: if R>=Ym then q=1, R<=(R-Ym)<<1, else q=0, R<=R<<1; Q<=(Q<<1)|q; counter increments.
REQ-017 The edge completing iteration P.NF+3 SHALL move BUSY to DONE; the counter is $clog2(P.NF+4) bits wide.
REQ-018 Qm SHALL equal floor(Xm/Ym * 2^(P.NF+2)); Sticky=(R!=0) after the last iteration.
REQ-019 Latency: Start accepted at edge 0 -> Done high during the cycle after edge P.NF+3, for exactly one cycle; DONE -> IDLE unconditionally on the next edge.
REQ-020 Qm, Sticky and DivErr SHALL hold their values from Done until the next accepted Start.
REQ-021 Start while in BUSY or DONE SHALL be ignored; there is no queuing.
REQ-022 Ym MSB=0 at accept: go directly to DONE; DivErr=1, Qm all ones, Sticky=1; Done the following cycle.
REQ-023 Flush=1 in any state: IDLE on the next edge; Done not asserted; Qm, Sticky and DivErr unchanged.
REQ-024 Start and Flush together in IDLE: Flush wins; remain in IDLE.
REQ-025 No combinational path from Start, Flush, Xm or Ym to any output.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, counter=0, R=0, Q=0, Qm=0, Sticky=0, DivErr=0, Done=0, Busy=0, Ready=1.
REQ-027 Reset mid-operation SHALL discard the operation without a Done pulse; the first Start after release SHALL be accepted normally.

Structure
REQ-028 The state enumerated type and the iteration-count constant (P.NF+3) SHALL reside in the shared cvw package; the width derives from P.NF.
REQ-029 The conditional subtract/shift SHALL be the single sub-module sigdiv_step (combinational; inputs R and Ym; outputs next R and q).

Verification (P.NF=23)
REQ-030 Xm=0x800000, Ym=0x800000, Start -> Done 27 cycles after accept; Qm=0x2000000, Sticky=0.
REQ-031 Xm=0x800000, Ym=0xC00000 -> Qm=0x1555555, Sticky=1.
REQ-032 Xm=0xC00000, Ym=0x800000 -> Qm=0x3000000, Sticky=0; a second Start raised during BUSY is ignored.
REQ-033 Ym=0x400000 -> Done the cycle after accept; DivErr=1, Qm=0x3FFFFFF, Sticky=1.
REQ-034 Flush at iteration 10 -> no Done; Ready=1 next cycle; Qm retains the prior result.
REQ-035 reset_n low at iteration 5, then released, then Start with REQ-030 operands -> all outputs at reset values, followed by the correct REQ-030 result.

Source files
------------

// File: rtl/sigdiv_iter_pkg.sv
// Shared configuration and state types for the iterative significand divider.
package sigdiv_iter_pkg;

  typedef struct packed {
    int NF;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{NF: 23};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sigdiv_state_t;

  // One quotient bit per iteration: integer bit plus NF+2 fraction bits.
  function automatic int sigdiv_iters(input int nf);
    return nf + 3;
  endfunction

  function automatic int sigdiv_cnt_w(input int nf);
    return $clog2(nf + 4);
  endfunction

endpackage

// File: rtl/sigdiv_step.sv
// One restoring radix-2 step: conditional subtract of the divisor, then shift.
module sigdiv_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] r,
  input  logic [W-2:0] ym,
  output logic [W-1:0] r_next,
  output logic         q
);

  logic [W-1:0] ym_ext;
  logic [W-1:0] diff;

  // Compare, subtract and shift the partial remainder.
  always_comb begin
    ym_ext = {1'b0, ym};
    diff   = r - ym_ext;
    if (r >= ym_ext) begin
      q      = 1'b1;
      r_next = {diff[W-2:0], 1'b0};
    end else begin
      q      = 1'b0;
      r_next = {r[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sigdiv_iter.sv
// Iterative restoring divider for normalized significands, one quotient bit per clock.
module sigdiv_iter
  import sigdiv_iter_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [P.NF:0]   Xm,
  input  logic [P.NF:0]   Ym,
  output logic            Ready,
  output logic            Busy,
  output logic            Done,
  output logic [P.NF+2:0] Qm,
  output logic            Sticky,
  output logic            DivErr
);

  localparam int NF    = P.NF;
  localparam int ITERS = sigdiv_iters(NF);
  localparam int CW    = sigdiv_cnt_w(NF);
  localparam int RW    = NF + 2;

  sigdiv_state_t   state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   r;
  logic [ITERS-1:0] q_acc;
  logic [NF:0]     ym_r;
  logic [RW-1:0]   r_next;
  logic            q_bit;

  sigdiv_step #(.W(RW)) u_step (
    .r      (r),
    .ym     (ym_r),
    .r_next (r_next),
    .q      (q_bit)
  );

  // Control FSM, datapath registers and registered status/result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      r      <= '0;
      q_acc  <= '0;
      ym_r   <= '0;
      Qm     <= '0;
      Sticky <= 1'b0;
      DivErr <= 1'b0;
      Ready  <= 1'b1;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else if (Flush) begin
      // Abort leaves the last result untouched.
      state <= IDLE;
      Ready <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            Ready <= 1'b0;
            if (!Ym[NF]) begin
              state  <= DONE;
              Done   <= 1'b1;
              DivErr <= 1'b1;
              Qm     <= '1;
              Sticky <= 1'b1;
            end else begin
              state <= BUSY;
              Busy  <= 1'b1;
              r     <= {1'b0, Xm};
              q_acc <= '0;
              cnt   <= '0;
              ym_r  <= Ym;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          r     <= r_next;
          q_acc <= {q_acc[ITERS-2:0], q_bit};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(ITERS - 1)) begin
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            Qm     <= {q_acc[ITERS-2:0], q_bit};
            Sticky <= |r_next;
            DivErr <= 1'b0;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
          Ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigdiv_iter.sv
// Self-checking bench for sigdiv_iter: arithmetic reference model plus directed literal vectors.
module tb_sigdiv_iter;
  import sigdiv_iter_pkg::*;

  localparam int   NF    = 23;
  localparam int   ITERS = NF + 3;
  localparam cvw_t CFG   = '{NF: 23};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          Start = 1'b0;
  logic          Flush = 1'b0;
  logic [NF:0]   Xm = '0;
  logic [NF:0]   Ym = '0;
  logic          Ready, Busy, Done, Sticky, DivErr;
  logic [NF+2:0] Qm;

  int checks = 0;
  int errors = 0;

  sigdiv_iter #(.P(CFG)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .Start  (Start),
    .Flush  (Flush),
    .Xm     (Xm),
    .Ym     (Ym),
    .Ready  (Ready),
    .Busy   (Busy),
    .Done   (Done),
    .Qm     (Qm),
    .Sticky (Sticky),
    .DivErr (DivErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: quotient scaled by 2^(NF+2), truncated.
  function automatic logic [NF+2:0] ref_quot(input logic [NF:0] x, input logic [NF:0] y);
    longint unsigned n;
    n = 64'(x) << (NF + 2);
    return (NF+3)'(n / 64'(y));
  endfunction

  function automatic bit ref_sticky(input logic [NF:0] x, input logic [NF:0] y);
    longint unsigned n;
    n = 64'(x) << (NF + 2);
    return (n % 64'(y)) != 64'd0;
  endfunction

  // Transaction-level model: busy for ITERS cycles, then a one-cycle result pulse.
  bit            m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
  bit            m_sticky = 1'b0, m_err = 1'b0, p_sticky = 1'b0;
  logic [NF+2:0] m_qm = '0, p_qm = '0;
  int            m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
      m_qm <= '0; m_sticky <= 1'b0; m_err <= 1'b0; m_left <= 0;
    end else if (Flush) begin
      m_ready <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_ready) begin
      if (Start) begin
        m_ready <= 1'b0;
        if (Ym[NF] == 1'b0) begin
          m_done <= 1'b1; m_qm <= '1; m_sticky <= 1'b1; m_err <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_left <= ITERS;
          p_qm <= ref_quot(Xm, Ym); p_sticky <= ref_sticky(Xm, Ym);
        end
      end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_qm <= p_qm; m_sticky <= p_sticky; m_err <= 1'b0;
      end
    end else if (m_done) begin
      m_done <= 1'b0; m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ready", Ready, m_ready);
    chk("busy", Busy, m_busy);
    chk("done", Done, m_done);
    chk("qm", Qm, m_qm);
    chk("sticky", Sticky, m_sticky);
    chk("diverr", DivErr, m_err);
  end

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // poke_at >= 0 raises a stray Start (with a bad divisor) that many cycles into the run.
  task automatic run_div(input string nm, input logic [NF:0] xm, input logic [NF:0] ym,
                         input int poke_at, input logic [NF+2:0] lit_qm,
                         input bit lit_st, input bit lit_err, input int lit_lat);
    int lat = -1;
    wait_ready();
    Xm = xm; Ym = ym; Start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == poke_at) begin
        Start = 1'b1; Xm = 24'h800000; Ym = 24'h400000;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        lat = k;
        break;
      end
    end
    Start = 1'b0;
    chk({nm, "_latency"}, 64'(lat), 64'(lit_lat));
    chk({nm, "_qm"}, Qm, lit_qm);
    chk({nm, "_sticky"}, Sticky, lit_st);
    chk({nm, "_diverr"}, DivErr, lit_err);
  endtask

  initial begin
    #6;
    chk("rst_ready", Ready, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_qm", Qm, 26'h0);
    chk("rst_sticky", Sticky, 1'b0);
    chk("rst_diverr", DivErr, 1'b0);
    #6 reset_n = 1'b1;

    run_div("one_by_one", 24'h800000, 24'h800000, -1, 26'h2000000, 1'b0, 1'b0, 26);
    run_div("two_thirds", 24'h800000, 24'hC00000, -1, 26'h1555555, 1'b1, 1'b0, 26);
    run_div("three_half", 24'hC00000, 24'h800000, 5, 26'h3000000, 1'b0, 1'b0, 26);

    // Flush partway through a divide: no pulse, previous result kept.
    wait_ready();
    Xm = 24'hC00000; Ym = 24'hA00000; Start = 1'b1;
    @(posedge clk);
    @(negedge clk) Start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk) Flush = 1'b0;
    chk("flush_ready", Ready, 1'b1);
    chk("flush_busy", Busy, 1'b0);
    chk("flush_qm_kept", Qm, 26'h3000000);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("flush_no_done", Done, 1'b0);
    end

    // Start and Flush together while idle.
    Xm = 24'h800000; Ym = 24'h800000; Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    chk("start_flush_ready", Ready, 1'b1);
    chk("start_flush_busy", Busy, 1'b0);

    run_div("div_err", 24'h800000, 24'h400000, -1, 26'h3FFFFFF, 1'b1, 1'b1, 0);

    // Reset in the middle of a divide.
    wait_ready();
    Xm = 24'h800000; Ym = 24'h800000; Start = 1'b1;
    @(posedge clk);
    @(negedge clk) Start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ready", Ready, 1'b1);
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    chk("midrst_qm", Qm, 26'h0);
    chk("midrst_sticky", Sticky, 1'b0);
    chk("midrst_diverr", DivErr, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    run_div("after_reset", 24'h800000, 24'h800000, -1, 26'h2000000, 1'b0, 1'b0, 26);
    run_div("nonunit", 24'hFFFFFF, 24'h800001, -1, ref_quot(24'hFFFFFF, 24'h800001),
            ref_sticky(24'hFFFFFF, 24'h800001), 1'b0, 26);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
